multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM for a small LEGv8 subset: sequences fetch, decode,
// execute, memory and write-back, with a memory-wait timeout and a sticky fault state.
module multi_cycle_control #(
    parameter int TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [10:0] Opcode,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        IMemReq,
    output logic        IRWrite,
    output logic        DMemRead,
    output logic        DMemWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic        Fault,
    output logic [2:0]  State
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE    = 3'd0,
        C_RTYPE   = 3'd1,
        C_LDUR    = 3'd2,
        C_STUR    = 3'd3,
        C_CBZ     = 3'd4,
        C_B       = 3'd5,
        C_ILLEGAL = 3'd6
    } class_t;

    state_t        r_state;
    class_t        r_class;
    logic [CW-1:0] r_wait;

    class_t        w_dec_class;
    class_t        w_class;
    logic          w_timeout;

    always_comb begin
        w_dec_class = C_ILLEGAL;
        casez (Opcode)
            11'b11111000010: w_dec_class = C_LDUR;
            11'b11111000000: w_dec_class = C_STUR;
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: w_dec_class = C_RTYPE;
            11'b10110100???: w_dec_class = C_CBZ;
            11'b000101?????: w_dec_class = C_B;
            default:         w_dec_class = C_ILLEGAL;
        endcase
    end

    // In DECODE the class register is not loaded yet, so selects come straight from the decoder.
    assign w_class   = (r_state == S_DECODE) ? w_dec_class : r_class;
    assign w_timeout = (r_wait == CW'(TIMEOUT)) && !MemReady;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= S_FETCH;
            r_class <= C_NONE;
            r_wait  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (MemReady) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + CW'(1);
                    end
                end
                S_DECODE: begin
                    r_class <= w_dec_class;
                    r_wait  <= '0;
                    case (w_dec_class)
                        C_ILLEGAL: r_state <= S_FAULT;
                        C_B:       r_state <= S_FETCH;
                        default:   r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    r_wait <= '0;
                    case (r_class)
                        C_RTYPE:       r_state <= S_WB;
                        C_LDUR, C_STUR: r_state <= S_MEM;
                        C_CBZ:         r_state <= S_FETCH;
                        default:       r_state <= S_FAULT;
                    endcase
                end
                S_MEM: begin
                    if (MemReady) begin
                        r_state <= (r_class == C_LDUR) ? S_WB : S_FETCH;
                        r_wait  <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + CW'(1);
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_wait  <= '0;
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                    r_wait  <= '0;
                end
                default: begin
                    r_state <= S_FAULT;
                    r_wait  <= '0;
                end
            endcase
        end
    end

    // Everything is forced low while reset is held, including the fetch request.
    always_comb begin
        IMemReq   = 1'b0;
        IRWrite   = 1'b0;
        DMemRead  = 1'b0;
        DMemWrite = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        Reg2Loc   = 1'b0;
        ALUSrc    = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUOp     = 2'b00;
        Fault     = 1'b0;
        State     = 3'd0;
        if (Reset_L) begin
            State = r_state;
            case (r_state)
                S_FETCH: begin
                    IMemReq = 1'b1;
                    IRWrite = MemReady;
                end
                S_DECODE: begin
                    if (w_dec_class == C_B) begin
                        PCWrite = 1'b1;
                        PCSrc   = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_class == C_CBZ) begin
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                    end
                end
                S_MEM: begin
                    if (r_class == C_LDUR) begin
                        DMemRead = 1'b1;
                    end else begin
                        DMemWrite = 1'b1;
                        PCWrite   = MemReady;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                end
                S_FAULT: Fault = 1'b1;
                default: Fault = 1'b0;
            endcase
            if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
                case (w_class)
                    C_RTYPE: ALUOp = 2'b10;
                    C_LDUR: begin
                        ALUSrc   = 1'b1;
                        MemToReg = 1'b1;
                    end
                    C_STUR: begin
                        Reg2Loc = 1'b1;
                        ALUSrc  = 1'b1;
                    end
                    C_CBZ: begin
                        Reg2Loc = 1'b1;
                        ALUOp   = 2'b01;
                    end
                    default: ALUOp = 2'b00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-cycle stimulus and expected output vectors
// are queued per instruction, then driven and compared cycle by cycle.
module tb_multi_cycle_control;

    localparam int W  = 16;
    localparam int TO = 15;

    localparam int K_R   = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_CBZ = 3;
    localparam int K_B   = 4;
    localparam int K_ILL = 5;

    localparam logic [6:0] E_IM = 7'b1000000;
    localparam logic [6:0] E_IR = 7'b0100000;
    localparam logic [6:0] E_DR = 7'b0010000;
    localparam logic [6:0] E_DW = 7'b0001000;
    localparam logic [6:0] E_PW = 7'b0000100;
    localparam logic [6:0] E_PS = 7'b0000010;
    localparam logic [6:0] E_RW = 7'b0000001;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [10:0] Opcode;
    logic        Zero;
    logic        MemReady;
    logic        IMemReq, IRWrite, DMemRead, DMemWrite, PCWrite, PCSrc;
    logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, Fault;
    logic [1:0]  ALUOp;
    logic [2:0]  State;

    logic [W-1:0] exp_q[$];
    logic [13:0]  stim_q[$];
    string        tag_q[$];
    logic [W-1:0] got;
    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    multi_cycle_control #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .IMemReq(IMemReq), .IRWrite(IRWrite), .DMemRead(DMemRead), .DMemWrite(DMemWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUOp(ALUOp), .Fault(Fault), .State(State)
    );

    // Layout: state, {imem, irw, dread, dwrite, pcw, pcsrc, regwrite}, {reg2loc, alusrc, memtoreg, aluop}, fault
    assign got = {State, IMemReq, IRWrite, DMemRead, DMemWrite, PCWrite, PCSrc, RegWrite,
                  Reg2Loc, ALUSrc, MemToReg, ALUOp, Fault};

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pk(input logic [2:0] st, input logic [6:0] en,
                                        input logic [4:0] sel, input logic f);
        return {st, en, sel, f};
    endfunction

    function automatic logic [4:0] sel_of(input int cls);
        case (cls)
            K_R:     return 5'b00010;
            K_LD:    return 5'b01100;
            K_ST:    return 5'b11000;
            K_CBZ:   return 5'b10001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic logic [10:0] op_of(input int cls);
        logic [10:0] r_ops[4];
        r_ops[0] = 11'b10001011000;
        r_ops[1] = 11'b11001011000;
        r_ops[2] = 11'b10001010000;
        r_ops[3] = 11'b10101010000;
        case (cls)
            K_R:     return r_ops[$urandom_range(0, 3)];
            K_LD:    return 11'b11111000010;
            K_ST:    return 11'b11111000000;
            K_CBZ:   return {8'b10110100, 3'($urandom_range(0, 7))};
            K_B:     return {6'b000101, 5'($urandom_range(0, 31))};
            default: return 11'b11111111111;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_cycle(input string tag, input logic rst, input logic mr, input logic z,
                             input logic [10:0] op, input logic [W-1:0] e);
        stim_q.push_back({rst, mr, z, op});
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic add_reset(input string tag, input int n);
        for (int i = 0; i < n; i++)
            add_cycle(tag, 1'b0, rb(), rb(), 11'($urandom_range(0, 2047)), '0);
    endtask

    task automatic add_fault(input string tag, input int n, input logic [10:0] op);
        for (int i = 0; i < n; i++)
            add_cycle(tag, 1'b1, rb(), rb(), op, pk(3'd5, 7'd0, 5'd0, 1'b1));
    endtask

    // fw/mw: MemReady-low cycles in FETCH/MEM; beyond TO means timeout, mw<0 leaves MEM unfinished.
    task automatic queue_instr(input string tag, input int cls, input logic [10:0] op,
                               input logic z, input int fw, input int mw);
        logic [4:0] sel;
        logic [6:0] strobe;
        sel = sel_of(cls);
        for (int i = 0; i < fw && i <= TO; i++)
            add_cycle({tag, ":fwait"}, 1'b1, 1'b0, rb(), op, pk(3'd0, E_IM, 5'd0, 1'b0));
        if (fw > TO) begin
            add_fault({tag, ":ftmo"}, 3, op);
            return;
        end
        add_cycle({tag, ":fetch"}, 1'b1, 1'b1, rb(), op, pk(3'd0, E_IM | E_IR, 5'd0, 1'b0));
        if (cls == K_ILL) begin
            add_cycle({tag, ":dec"}, 1'b1, rb(), rb(), op, pk(3'd1, 7'd0, 5'd0, 1'b0));
            add_fault({tag, ":fault"}, 3, op);
            return;
        end
        if (cls == K_B) begin
            add_cycle({tag, ":dec"}, 1'b1, rb(), rb(), op, pk(3'd1, E_PW | E_PS, sel, 1'b0));
            return;
        end
        add_cycle({tag, ":dec"}, 1'b1, rb(), rb(), op, pk(3'd1, 7'd0, sel, 1'b0));
        if (cls == K_CBZ) begin
            add_cycle({tag, ":exec"}, 1'b1, rb(), z, op, pk(3'd2, E_PW | (z ? E_PS : 7'd0), sel, 1'b0));
            return;
        end
        add_cycle({tag, ":exec"}, 1'b1, rb(), rb(), op, pk(3'd2, 7'd0, sel, 1'b0));
        if (cls == K_R) begin
            add_cycle({tag, ":wb"}, 1'b1, rb(), rb(), op, pk(3'd4, E_RW | E_PW, sel, 1'b0));
            return;
        end
        strobe = (cls == K_LD) ? E_DR : E_DW;
        if (mw < 0) begin
            add_cycle({tag, ":mem"}, 1'b1, 1'b0, rb(), op, pk(3'd3, strobe, sel, 1'b0));
            return;
        end
        for (int i = 0; i < mw && i <= TO; i++)
            add_cycle({tag, ":mwait"}, 1'b1, 1'b0, rb(), op, pk(3'd3, strobe, sel, 1'b0));
        if (mw > TO) begin
            add_fault({tag, ":mtmo"}, 3, op);
            return;
        end
        if (cls == K_LD) begin
            add_cycle({tag, ":mem"}, 1'b1, 1'b1, rb(), op, pk(3'd3, E_DR, sel, 1'b0));
            add_cycle({tag, ":wb"}, 1'b1, rb(), rb(), op, pk(3'd4, E_RW | E_PW, sel, 1'b0));
        end else begin
            add_cycle({tag, ":mem"}, 1'b1, 1'b1, rb(), op, pk(3'd3, E_DW | E_PW, sel, 1'b0));
        end
    endtask

    task automatic run_queue();
        logic [13:0] s;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            s = stim_q.pop_front();
            Reset_L  = s[13];
            MemReady = s[12];
            Zero     = s[11];
            Opcode   = s[10:0];
            #2;
            check_val(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    initial begin
        int cls;
        Reset_L  = 1'b0;
        Opcode   = '0;
        Zero     = 1'b0;
        MemReady = 1'b0;

        add_reset("reset", 2);
        queue_instr("add", K_R, 11'b10001011000, 1'b0, 0, 0);
        queue_instr("sub", K_R, 11'b11001011000, 1'b0, 0, 0);
        queue_instr("and", K_R, 11'b10001010000, 1'b0, 1, 0);
        queue_instr("orr", K_R, 11'b10101010000, 1'b0, 0, 0);
        queue_instr("ldur_w3", K_LD, op_of(K_LD), 1'b0, 0, 3);
        queue_instr("ldur", K_LD, op_of(K_LD), 1'b0, 2, 0);
        queue_instr("stur", K_ST, op_of(K_ST), 1'b0, 0, 1);
        queue_instr("cbz_z1", K_CBZ, op_of(K_CBZ), 1'b1, 0, 0);
        queue_instr("cbz_z0", K_CBZ, op_of(K_CBZ), 1'b0, 0, 0);
        queue_instr("b", K_B, op_of(K_B), 1'b0, 0, 0);
        queue_instr("fetch_edge", K_R, op_of(K_R), 1'b0, TO, 0);
        queue_instr("mem_edge", K_ST, op_of(K_ST), 1'b0, 0, TO);
        queue_instr("stur_abort", K_ST, op_of(K_ST), 1'b0, 0, -1);
        add_reset("abort_rst", 2);
        queue_instr("b_after_rst", K_B, op_of(K_B), 1'b0, 0, 0);
        queue_instr("illegal", K_ILL, 11'b11111111111, 1'b0, 0, 0);
        add_reset("ill_rst", 2);
        queue_instr("fetch_tmo", K_R, op_of(K_R), 1'b0, TO + 1, 0);
        add_reset("ftmo_rst", 2);
        queue_instr("mem_tmo", K_LD, op_of(K_LD), 1'b0, 0, TO + 1);
        add_reset("mtmo_rst", 1);
        for (int i = 0; i < 25; i++) begin
            cls = int'($urandom_range(0, 4));
            queue_instr("rand", cls, op_of(cls), rb(), int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 3)));
        end
        run_queue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
